// File: rtl/pattern_pkg.sv
// Shared types and default sizes for the pattern serializer and the
// sequence-detector benches that consume its stream.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int PAT_WIDTH = 16;
  localparam int PAT_CNT_W = 5;

endpackage

// File: rtl/pattern_serializer.sv
// Parallel-to-serial stimulus source: loads a pattern on start and drives it
// MSB first onto x, one bit per clock, with pause, busy and a done pulse.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH = PAT_WIDTH,
  parameter int CNT_W = PAT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] nbits,
  input  logic             pause,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] eff_len;

  assign shifted = shreg << 1;

  // Zero or an over-long request both mean "send the whole pattern".
  assign eff_len = (nbits == '0 || nbits > CNT_WIDTH) ? CNT_WIDTH : nbits;

  // NOTE: every register, outputs included, sits in one non-blocking always_ff
  // with an async reset, so outputs drop the instant reset rises and no
  // combinational path from inputs reaches x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      remaining <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg     <= din;
            remaining <= eff_len;
            x         <= din[WIDTH-1];
            x_valid   <= 1'b1;
            busy      <= 1'b1;
            state     <= SHIFT;
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end

        SHIFT: begin
          if (!pause) begin
            shreg     <= shifted;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              x       <= 1'b0;
              x_valid <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              x <= shifted[WIDTH-1];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
